// File: rtl/eth_tx_scheduler.sv
// Round-robin frame scheduler between two dibit sources and the Ethernet TX packer.
// Streams FRAME_DIBITS dibits per grant; cancels on source underrun or packer timeout.
module eth_tx_scheduler #(
  parameter int          FRAME_DIBITS = 1280,
  parameter logic [15:0] TIMEOUT      = 16'd8192
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        enable,
  input  logic [1:0]  req,
  input  logic [1:0]  src_valid,
  input  logic [1:0]  src0_d,
  input  logic [1:0]  src1_d,
  output logic [1:0]  src_pop,
  output logic [1:0]  src_abort,
  output logic [1:0]  grant,
  input  logic        pk_stall,
  output logic        pk_axiiv,
  output logic [1:0]  pk_axiid,
  output logic        pk_cancel,
  output logic [15:0] frames_sent,
  output logic [15:0] frames_cancelled
);

  typedef enum logic [1:0] {IDLE, WAIT, STREAM, DONE} state_t;

  state_t      state, state_next;
  logic        last_served;
  logic [12:0] beat_cnt;
  logic [15:0] tmo_cnt;
  logic [1:0]  pick;

  logic g, cur_valid, active, beat, underrun, timeout, cancel, last_beat;

  assign g         = grant[1];
  assign cur_valid = g ? src_valid[1] : src_valid[0];

  // Combinational outputs are gated by rst so a mid-frame reset never emits a cancel or pop.
  assign active    = !rst && (state == WAIT || state == STREAM);
  assign beat      = active && !pk_stall && cur_valid;
  assign underrun  = active && !pk_stall && !cur_valid;
  assign timeout   = !rst && (state == WAIT) && pk_stall && (tmo_cnt == TIMEOUT - 16'd1);
  assign cancel    = underrun || timeout;
  assign last_beat = beat && (beat_cnt == 13'(FRAME_DIBITS - 1));

  assign pk_axiiv  = beat;
  assign pk_axiid  = beat ? (g ? src1_d : src0_d) : 2'b00;
  assign src_pop   = beat ? grant : 2'b00;
  assign pk_cancel = cancel;
  assign src_abort = cancel ? grant : 2'b00;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch is inferred.
    pick = 2'b00;
    case (req)
      2'b01:   pick = 2'b01;
      2'b10:   pick = 2'b10;
      2'b11:   pick = last_served ? 2'b01 : 2'b10;
      default: pick = 2'b00;
    endcase
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:         if (enable && req != 2'b00) state_next = WAIT;
      WAIT, STREAM: begin
        if (cancel)         state_next = IDLE;
        else if (last_beat) state_next = DONE;
        else if (beat)      state_next = STREAM;
      end
      DONE:         if (pk_stall) state_next = IDLE;
      default:      state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (rst) begin
      state            <= IDLE;
      grant            <= 2'b00;
      last_served      <= 1'b1;
      beat_cnt         <= '0;
      tmo_cnt          <= '0;
      frames_sent      <= '0;
      frames_cancelled <= '0;
    end else begin
      state <= state_next;

      if (state == IDLE && state_next == WAIT) begin
        grant    <= pick;
        beat_cnt <= '0;
        tmo_cnt  <= '0;
      end else if (state == WAIT && pk_stall && tmo_cnt != 16'hFFFF) begin
        tmo_cnt <= tmo_cnt + 16'd1;
      end

      if (beat) beat_cnt <= beat_cnt + 13'd1;

      if (last_beat) begin
        grant       <= 2'b00;
        last_served <= g;
        frames_sent <= frames_sent + 16'd1;
      end

      if (cancel) begin
        grant            <= 2'b00;
        last_served      <= g;
        frames_cancelled <= frames_cancelled + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_eth_tx_scheduler.sv
// Self-checking bench for eth_tx_scheduler: random source data and packer stalls checked
// against a frame-level round-robin model and per-source FIFO data queues.
module tb_eth_tx_scheduler;
  localparam int          FD  = 1280;
  localparam logic [15:0] TMO = 16'd16;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        enable = 1'b0;
  logic [1:0]  req = 2'b00;
  logic [1:0]  src_valid = 2'b00;
  logic [1:0]  src0_d = 2'b00;
  logic [1:0]  src1_d = 2'b00;
  logic        pk_stall = 1'b1;
  logic [1:0]  src_pop, src_abort, grant, pk_axiid;
  logic        pk_axiiv, pk_cancel;
  logic [15:0] frames_sent, frames_cancelled;

  eth_tx_scheduler #(.FRAME_DIBITS(FD), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst(rst), .enable(enable), .req(req), .src_valid(src_valid),
    .src0_d(src0_d), .src1_d(src1_d), .src_pop(src_pop), .src_abort(src_abort),
    .grant(grant), .pk_stall(pk_stall), .pk_axiiv(pk_axiiv), .pk_axiid(pk_axiid),
    .pk_cancel(pk_cancel), .frames_sent(frames_sent), .frames_cancelled(frames_cancelled)
  );

  always #5 clk = ~clk;

  int checks = 0, passed = 0, data_err = 0, pops = 0;
  logic [1:0] q0[$], q1[$];

  logic [1:0]  s_grant, s_pop, s_abort, s_axiid;
  logic        s_cancel, s_axiiv;
  logic [15:0] s_sent, s_canc;

  // Frame-level model: who was served last and how many frames finished either way.
  logic        m_last = 1'b1;
  logic [15:0] m_sent = '0, m_canc = '0;

  logic [1:0]  r_g_req, r_g_seen, r_g_done;
  logic [15:0] r_sent_done;
  int          r_grant_err, r_cyc, r_stall, r_pad;

  function automatic logic [1:0] exp_pick(input logic [1:0] r);
    if (r == 2'b11) return m_last ? 2'b01 : 2'b10;
    return r;
  endfunction

  task automatic cycle(input logic stall_v, input logic [1:0] valid_v);
    pk_stall  = stall_v;
    src_valid = valid_v;
    if (q0.size() == 0) q0.push_back(2'($urandom));
    if (q1.size() == 0) q1.push_back(2'($urandom));
    src0_d = q0[0];
    src1_d = q1[0];
    @(negedge clk);
    s_grant = grant; s_pop = src_pop; s_abort = src_abort; s_cancel = pk_cancel;
    s_axiiv = pk_axiiv; s_axiid = pk_axiid; s_sent = frames_sent; s_canc = frames_cancelled;
    if (src_pop == 2'b11) data_err++;
    if (src_pop[0]) begin
      pops++;
      if (pk_axiid !== q0[0]) data_err++;
      void'(q0.pop_front());
    end
    if (src_pop[1]) begin
      pops++;
      if (pk_axiid !== q1[0]) data_err++;
      void'(q1.pop_front());
    end
    if (pk_axiiv !== (|src_pop)) data_err++;
    if (!pk_axiiv && pk_axiid !== 2'b00) data_err++;
    if ((|src_pop) && stall_v) data_err++;
    if ((src_pop & ~valid_v) != 2'b00) data_err++;
    if ((src_pop & ~grant) != 2'b00) data_err++;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1; req = 2'b00;
    cycle(1'b1, 2'b11);
    cycle(1'b1, 2'b11);
    rst = 1'b0;
    m_last = 1'b1; m_sent = '0; m_canc = '0;
  endtask

  // mode 0: packer never stalls, 1: stall toggles starting high, 2: random 25% stalls.
  task automatic run_frame(input logic [1:0] req_v, input int mode);
    logic st;
    int p0;
    enable = 1'b1; req = req_v;
    cycle(1'b1, 2'b11);
    r_g_req = s_grant;
    req = 2'b00;
    pops = 0; r_cyc = 0; r_stall = 0; r_grant_err = 0; r_g_seen = 2'b00;
    while (pops < FD && r_cyc < 4 * FD + 64) begin
      case (mode)
        0:       st = 1'b0;
        1:       st = (r_cyc % 2 == 0);
        default: st = ($urandom_range(0, 3) == 0);
      endcase
      cycle(st, 2'b11);
      if (r_cyc == 0) r_g_seen = s_grant;
      else if (s_grant !== r_g_seen) r_grant_err++;
      r_stall += int'(st);
      r_cyc++;
    end
    p0 = pops;
    cycle(1'b0, 2'b11);
    r_g_done = s_grant; r_sent_done = s_sent; r_pad = pops - p0;
    cycle(1'b1, 2'b11);
    cycle(1'b1, 2'b11);
  endtask

  task automatic test_reset();
    do_reset();
    cycle(1'b0, 2'b11);
    checks++; if (s_grant !== 2'b00) $display("FAIL reset_grant: got %b expected 00", s_grant); else passed++;
    checks++; if ({s_pop, s_abort, s_cancel, s_axiiv, s_axiid} !== 8'h00)
      $display("FAIL reset_comb_outputs: got %b expected 0", {s_pop, s_abort, s_cancel, s_axiiv, s_axiid}); else passed++;
    checks++; if (s_sent !== 16'd0) $display("FAIL reset_frames_sent: got %0d expected 0", s_sent); else passed++;
    checks++; if (s_canc !== 16'd0) $display("FAIL reset_frames_cancelled: got %0d expected 0", s_canc); else passed++;
  endtask

  task automatic test_single();
    logic [1:0] exp;
    data_err = 0;
    exp = exp_pick(2'b01);
    run_frame(2'b01, 0);
    m_last = exp[1]; m_sent++;
    checks++; if (r_g_req !== 2'b00) $display("FAIL single_grant_latency: got %b expected 00", r_g_req); else passed++;
    checks++; if (r_g_seen !== exp) $display("FAIL single_grant: got %b expected %b", r_g_seen, exp); else passed++;
    checks++; if (r_grant_err !== 0) $display("FAIL single_grant_held: got %0d drops expected 0", r_grant_err); else passed++;
    checks++; if (pops !== FD) $display("FAIL single_pops: got %0d expected %0d", pops, FD); else passed++;
    checks++; if (r_cyc !== FD) $display("FAIL single_cycles: got %0d expected %0d", r_cyc, FD); else passed++;
    checks++; if (data_err !== 0) $display("FAIL single_data: got %0d errors expected 0", data_err); else passed++;
    checks++; if (r_g_done !== 2'b00) $display("FAIL single_grant_done: got %b expected 00", r_g_done); else passed++;
    checks++; if (r_sent_done !== m_sent) $display("FAIL single_frames_sent: got %0d expected %0d", r_sent_done, m_sent); else passed++;
    checks++; if (r_pad !== 0) $display("FAIL single_pad_pops: got %0d expected 0", r_pad); else passed++;
  endtask

  task automatic test_tie();
    logic [1:0] exp;
    do_reset();
    data_err = 0;
    for (int f = 0; f < 4; f++) begin
      exp = exp_pick(2'b11);
      run_frame(2'b11, 2);
      m_last = exp[1]; m_sent++;
      checks++; if (r_g_seen !== exp) $display("FAIL tie_grant_%0d: got %b expected %b", f, r_g_seen, exp); else passed++;
      checks++; if (r_cyc !== FD + r_stall)
        $display("FAIL tie_cycles_%0d: got %0d expected %0d", f, r_cyc, FD + r_stall); else passed++;
    end
    checks++; if (r_sent_done !== m_sent) $display("FAIL tie_frames_sent: got %0d expected %0d", r_sent_done, m_sent); else passed++;
    checks++; if (data_err !== 0) $display("FAIL tie_data: got %0d errors expected 0", data_err); else passed++;
  endtask

  task automatic test_pause();
    logic [1:0] exp;
    data_err = 0;
    exp = exp_pick(2'b10);
    run_frame(2'b10, 1);
    m_last = exp[1]; m_sent++;
    checks++; if (r_g_seen !== exp) $display("FAIL pause_grant: got %b expected %b", r_g_seen, exp); else passed++;
    checks++; if (pops !== FD) $display("FAIL pause_pops: got %0d expected %0d", pops, FD); else passed++;
    checks++; if (r_cyc !== 2 * FD) $display("FAIL pause_cycles: got %0d expected %0d", r_cyc, 2 * FD); else passed++;
    checks++; if (data_err !== 0) $display("FAIL pause_data: got %0d errors expected 0", data_err); else passed++;
  endtask

  task automatic test_underrun();
    logic [1:0] exp;
    int n;
    data_err = 0;
    exp = exp_pick(2'b01);
    enable = 1'b1; req = 2'b01;
    cycle(1'b1, 2'b11);
    req = 2'b00; pops = 0; n = 0;
    while (pops < 500 && n < 1000) begin cycle(1'b0, 2'b11); n++; end
    cycle(1'b0, 2'b10);
    m_canc++; m_last = exp[1];
    checks++; if (s_cancel !== 1'b1) $display("FAIL underrun_cancel: got %b expected 1", s_cancel); else passed++;
    checks++; if (s_abort !== exp) $display("FAIL underrun_abort: got %b expected %b", s_abort, exp); else passed++;
    checks++; if (pops !== 500) $display("FAIL underrun_pops: got %0d expected 500", pops); else passed++;
    cycle(1'b1, 2'b11);
    checks++; if ({s_cancel, s_abort, s_grant} !== 5'b0) $display("FAIL underrun_pulse_end: got %b expected 0", {s_cancel, s_abort, s_grant}); else passed++;
    checks++; if (s_canc !== m_canc) $display("FAIL underrun_frames_cancelled: got %0d expected %0d", s_canc, m_canc); else passed++;
    exp = exp_pick(2'b11);
    run_frame(2'b11, 2);
    m_last = exp[1]; m_sent++;
    checks++; if (r_g_seen !== exp) $display("FAIL underrun_next_grant: got %b expected %b", r_g_seen, exp); else passed++;
    checks++; if (data_err !== 0) $display("FAIL underrun_data: got %0d errors expected 0", data_err); else passed++;
  endtask

  task automatic test_timeout();
    logic [1:0] exp, ab;
    int k;
    exp = exp_pick(2'b10);
    enable = 1'b1; req = 2'b10;
    cycle(1'b1, 2'b11);
    req = 2'b00; pops = 0; k = 0; ab = 2'b00;
    while (k < 64) begin
      cycle(1'b1, 2'b11);
      k++;
      if (s_cancel) begin ab = s_abort; break; end
    end
    m_canc++; m_last = exp[1];
    checks++; if (k !== int'(TMO)) $display("FAIL timeout_cycle: got %0d expected %0d", k, TMO); else passed++;
    checks++; if (ab !== exp) $display("FAIL timeout_abort: got %b expected %b", ab, exp); else passed++;
    checks++; if (pops !== 0) $display("FAIL timeout_pops: got %0d expected 0", pops); else passed++;
    cycle(1'b1, 2'b11);
    checks++; if (s_grant !== 2'b00) $display("FAIL timeout_grant_clear: got %b expected 00", s_grant); else passed++;
    checks++; if (s_canc !== m_canc) $display("FAIL timeout_frames_cancelled: got %0d expected %0d", s_canc, m_canc); else passed++;
  endtask

  task automatic test_reset_mid_frame();
    logic [1:0] exp;
    int n;
    enable = 1'b1; req = 2'b01;
    cycle(1'b1, 2'b11);
    req = 2'b00; pops = 0; n = 0;
    while (pops < 300 && n < 1000) begin cycle(1'b0, 2'b11); n++; end
    rst = 1'b1;
    cycle(1'b0, 2'b00);
    checks++; if ({s_cancel, s_abort, s_pop} !== 5'b0) $display("FAIL rstmid_no_pulse: got %b expected 0", {s_cancel, s_abort, s_pop}); else passed++;
    rst = 1'b0;
    m_last = 1'b1; m_sent = '0; m_canc = '0;
    cycle(1'b0, 2'b11);
    checks++; if ({s_grant, s_pop, s_abort, s_cancel, s_axiiv, s_axiid} !== 10'b0)
      $display("FAIL rstmid_outputs: got %b expected 0", {s_grant, s_pop, s_abort, s_cancel, s_axiiv, s_axiid}); else passed++;
    checks++; if ({s_sent, s_canc} !== 32'd0) $display("FAIL rstmid_counters: got %0d/%0d expected 0/0", s_sent, s_canc); else passed++;
    data_err = 0;
    exp = exp_pick(2'b11);
    run_frame(2'b11, 0);
    m_last = exp[1]; m_sent++;
    checks++; if (r_g_seen !== exp) $display("FAIL rstmid_tie_grant: got %b expected %b", r_g_seen, exp); else passed++;
    checks++; if (r_sent_done !== m_sent) $display("FAIL rstmid_frames_sent: got %0d expected %0d", r_sent_done, m_sent); else passed++;
    checks++; if (data_err !== 0) $display("FAIL rstmid_data: got %0d errors expected 0", data_err); else passed++;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_single();
    test_tie();
    test_pause();
    test_underrun();
    test_timeout();
    test_reset_mid_frame();
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/eth_tx_scheduler.md
# eth_tx_scheduler

Frame-level scheduler that shares the Ethernet transmit packer between two dibit-stream sources. Each source is, for example, a lightboard-frame FIFO or an audio FIFO. The scheduler grants one source per Ethernet frame using round-robin, and streams exactly FRAME_DIBITS payload dibits into the packer during the packer's data window. It cancels the packer's frame on source underrun or packer timeout, and keeps sent/cancelled frame statistics. It sits between the source FIFOs and the packer's axiiv/axiid/stall/cancelled ports.

## Interface
Parameters:
- FRAME_DIBITS, 1280: payload dibits per frame (320 bytes); legal range 1..8191.
- TIMEOUT, 16'd8192: maximum cycles spent in WAIT with pk_stall high before cancelling.

Ports:
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-high.
- enable  in  1  permits new grants; has no effect on a frame already granted.
- req  in  2  req[i]=1 means source i holds at least one full frame.
- src_valid  in  2  source i's current dibit is valid (first-word-fall-through).
- src0_d, src1_d  in  2 each  current dibit of source 0 and source 1.
- src_pop  out  2  one-hot pop to the granted source; one dibit is consumed per cycle it is high.
- src_abort  out  2  one-cycle pulse; the source must discard the remainder of its current frame.
- grant  out  2  one-hot registered grant; 0 when no source is granted.
- pk_stall  in  1  packer stall; 0 means the packer accepts a dibit this cycle.
- pk_axiiv  out  1  dibit valid to the packer.
- pk_axiid  out  2  dibit to the packer.
- pk_cancel  out  1  one-cycle pulse to the packer's cancelled input.
- frames_sent  out  16  count of completed frames; wraps.
- frames_cancelled  out  16  count of cancelled frames; wraps.

## Operation
- State IDLE: grant=0.
  - If enable and req!=0: pick the granted source and go to WAIT.
  - If only one req bit is set, that source is picked.
  - If both are set, the source not equal to last_served is picked.
  - last_served resets to 1, so source 0 wins the first tie.
- State WAIT: grant held; clear the timeout counter and the beat counter on entry.
  - A beat occurs when pk_stall=0 and src_valid[g]=1. On a beat: pk_axiiv=1, pk_axiid=src_d of the granted source, src_pop[g]=1, beat counter increments, go to STREAM.
  - pk_stall=0 with src_valid[g]=0 is an underrun.
  - If pk_stall stays high for TIMEOUT consecutive cycles, the frame is cancelled.
- State STREAM: beats proceed as in WAIT.
  - pk_stall=1 is a legal pause; nothing is popped during a pause.
  - A beat that brings the count to FRAME_DIBITS goes to DONE and sets last_served=g.
  - pk_stall=0 with src_valid[g]=0 is an underrun.
- State DONE:
  - frames_sent increments on the cycle DONE is entered.
  - grant drops to 0.
  - If pk_stall is low during DONE, pad: pk_axiiv=0, pk_axiid=0, no pop.
  - Go to IDLE when pk_stall=1.
- Cancel (underrun or timeout), all in one cycle:
  - pk_cancel=1 and src_abort[g]=1.
  - frames_cancelled increments.
  - last_served=g.
  - Go to IDLE.
- Outputs outside a beat: pk_axiiv=0, pk_axiid=0, src_pop=0.
- Reset value of every output is 0, as are the state, both counters and the beat counter (state is IDLE).
- Reset mid-frame: no pk_cancel and no src_abort are emitted; the packer and sources share rst.
- req is sampled only in IDLE; req dropping after grant is ignored.

## Timing
- Grant latency: req asserted in IDLE in cycle N → grant visible in cycle N+1.
- Data path: pk_axiid, pk_axiiv and src_pop are combinational from pk_stall, src_valid and the src data, with 0-cycle latency.
- Beat counter is 13 bits. Timeout counter is 16 bits and saturates.
- Last beat in cycle N → frames_sent updated at N+1 and grant=0 at N+1.
- Cancel is detected in cycle N and pk_cancel asserts in cycle N (combinational).
  - Grant clears at N+1.
  - A new grant is possible at N+2 at the earliest.
- Back-to-back frames: DONE→IDLE→WAIT adds at least 2 cycles. The packer's CRC and IFG time dominates this gap.

## Test plan
- Single source: req=01, src_valid=11, packer data window 1280 cycles → exactly 1280 pops; pk_axiid matches the source sequence; frames_sent=1; grant=01 from req+1 cycle until the last beat.
- Tie: req=11 held for 4 frames → grant sequence 01,10,01,10; frames_sent=4.
- Pause: pk_stall toggles 1/0 every cycle during data → pops only when stall=0; total pops still FRAME_DIBITS.
- Underrun: src_valid[0] drops at beat 500 while stall=0 → pk_cancel and src_abort=01 pulse for 1 cycle; frames_cancelled=1; next frame goes to source 1 if it requests.
- Timeout: TIMEOUT=16, pk_stall held at 1 after grant → pk_cancel pulses on the 16th WAIT cycle; zero pops.
- Reset at beat 300 → all outputs 0 on the next cycle; no cancel or abort pulse; the next tie goes to source 0.
